// File: rtl/fu_pkg.sv
// Shared types and constants for the execute/writeback slice: ALU op encoding,
// RISC-V major opcodes, MEM FSM states and FU port indices.
package fu_pkg;

    localparam int N_FU    = 3;
    localparam int N_WB    = 2;
    localparam int FU_ALU0 = 0;
    localparam int FU_ALU1 = 1;
    localparam int FU_MEM  = 2;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_XOR = 3'd2,
        ALU_SRA = 3'd3,
        ALU_AND = 3'd4
    } alu_op_e;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    typedef enum logic [1:0] {
        MEM_IDLE = 2'd0,
        MEM_REQ  = 2'd1,
        MEM_WAIT = 2'd2,
        MEM_DONE = 2'd3
    } mem_state_e;

endpackage

// File: rtl/fu_alu.sv
// Combinational ALU: selects src2 or immediate by opcode and flags whether the
// opcode/alu_op pair is one this FU can execute.
module fu_alu
    import fu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [6:0]      opcode_i,
    input  logic [2:0]      alu_op_i,
    input  logic [XLEN-1:0] src1_i,
    input  logic [XLEN-1:0] src2_i,
    input  logic [XLEN-1:0] imm_i,
    output logic [XLEN-1:0] result_o,
    output logic            valid_o
);

    logic [XLEN-1:0] op_b;

    always_comb begin
        op_b     = (opcode_i == OP_I) ? imm_i : src2_i;
        result_o = '0;
        valid_o  = (opcode_i == OP_R) || (opcode_i == OP_I);
        case (alu_op_e'(alu_op_i))
            ALU_ADD: result_o = src1_i + op_b;
            ALU_SUB: result_o = src1_i - op_b;
            ALU_XOR: result_o = src1_i ^ op_b;
            ALU_SRA: result_o = $signed(src1_i) >>> op_b[4:0];
            ALU_AND: result_o = src1_i & op_b;
            default: valid_o  = 1'b0;
        endcase
    end

endmodule

// File: rtl/fu_writeback_unit.sv
// Executes ops issued on ALU0/ALU1/MEM, runs the data-memory handshake and
// arbitrates completed results onto two writeback ports (MEM > ALU0 > ALU1).
module fu_writeback_unit
    import fu_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 6
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_FU-1:0]        iss_valid_i,
    input  logic [N_FU*7-1:0]      iss_opcode_i,
    input  logic [N_FU*3-1:0]      iss_alu_op_i,
    input  logic [N_FU*TAG_W-1:0]  iss_rd_i,
    input  logic [N_FU*XLEN-1:0]   iss_src1_i,
    input  logic [N_FU*XLEN-1:0]   iss_src2_i,
    input  logic [N_FU*XLEN-1:0]   iss_imm_i,
    output logic [N_FU-1:0]        fu_avail_o,
    output logic                   mem_req_valid_o,
    input  logic                   mem_req_ready_i,
    output logic                   mem_we_o,
    output logic [XLEN-1:0]        mem_addr_o,
    output logic [XLEN-1:0]        mem_wdata_o,
    input  logic                   mem_resp_valid_i,
    input  logic [XLEN-1:0]        mem_rdata_i,
    output logic [N_WB-1:0]        wb_valid_o,
    output logic [N_WB*TAG_W-1:0]  wb_tag_o,
    output logic [N_WB*XLEN-1:0]   wb_data_o
);

    logic [N_FU-1:0]  fu_avail_q, fu_avail_d;
    logic [1:0]       alu_full, alu_grant, alu_free_d;
    logic [TAG_W-1:0] alu_tag  [2];
    logic [XLEN-1:0]  alu_data [2];

    mem_state_e       mem_state_q, mem_state_d;
    logic [TAG_W-1:0] mem_tag_q, mem_tag_d;
    logic [XLEN-1:0]  mem_addr_q, mem_addr_d;
    logic [XLEN-1:0]  mem_wdata_q, mem_wdata_d;
    logic [XLEN-1:0]  mem_data_q, mem_data_d;
    logic             mem_we_q, mem_we_d;
    logic             mem_full, mem_issue;

    // MEM always wins a port; ALU1 loses only when MEM and ALU0 both hold results.
    assign mem_full     = (mem_state_q == MEM_DONE);
    assign alu_grant[0] = alu_full[0];
    assign alu_grant[1] = alu_full[1] & ~(mem_full & alu_full[0]);

    for (genvar gi = 0; gi < 2; gi++) begin : g_alu
        logic [XLEN-1:0]  res;
        logic             ok;
        logic             full_q, full_d;
        logic [TAG_W-1:0] tag_q, tag_d;
        logic [XLEN-1:0]  data_q, data_d;

        fu_alu #(.XLEN(XLEN)) u_alu (
            .opcode_i (iss_opcode_i[gi*7 +: 7]),
            .alu_op_i (iss_alu_op_i[gi*3 +: 3]),
            .src1_i   (iss_src1_i[gi*XLEN +: XLEN]),
            .src2_i   (iss_src2_i[gi*XLEN +: XLEN]),
            .imm_i    (iss_imm_i[gi*XLEN +: XLEN]),
            .result_o (res),
            .valid_o  (ok)
        );

        always_comb begin
            full_d = full_q;
            tag_d  = tag_q;
            data_d = data_q;
            if (alu_grant[gi]) begin
                full_d = 1'b0;
            end
            if (iss_valid_i[gi] && fu_avail_q[gi] && ok) begin
                full_d = 1'b1;
                tag_d  = iss_rd_i[gi*TAG_W +: TAG_W];
                data_d = res;
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                full_q <= 1'b0;
                tag_q  <= '0;
                data_q <= '0;
            end else begin
                full_q <= full_d;
                tag_q  <= tag_d;
                data_q <= data_d;
            end
        end

        assign alu_full[gi]   = full_q;
        assign alu_free_d[gi] = ~full_d;
        assign alu_tag[gi]    = tag_q;
        assign alu_data[gi]   = data_q;
    end

    // MEM issue needs a load/store opcode; the address is always an ADD.
    assign mem_issue = iss_valid_i[FU_MEM] && (mem_state_q == MEM_IDLE)
                    && (iss_alu_op_i[FU_MEM*3 +: 3] == ALU_ADD)
                    && ((iss_opcode_i[FU_MEM*7 +: 7] == OP_LOAD)
                     || (iss_opcode_i[FU_MEM*7 +: 7] == OP_STORE));

    always_comb begin
        mem_state_d = mem_state_q;
        mem_tag_d   = mem_tag_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_data_d  = mem_data_q;
        mem_we_d    = mem_we_q;
        case (mem_state_q)
            MEM_IDLE: if (mem_issue) begin
                mem_state_d = MEM_REQ;
                mem_tag_d   = iss_rd_i[FU_MEM*TAG_W +: TAG_W];
                mem_addr_d  = iss_src1_i[FU_MEM*XLEN +: XLEN] + iss_imm_i[FU_MEM*XLEN +: XLEN];
                mem_wdata_d = iss_src2_i[FU_MEM*XLEN +: XLEN];
                mem_we_d    = (iss_opcode_i[FU_MEM*7 +: 7] == OP_STORE);
            end
            MEM_REQ: if (mem_req_ready_i) begin
                mem_state_d = mem_we_q ? MEM_IDLE : MEM_WAIT;
            end
            MEM_WAIT: if (mem_resp_valid_i) begin
                mem_state_d = MEM_DONE;
                mem_data_d  = mem_rdata_i;
            end
            MEM_DONE: mem_state_d = MEM_IDLE;
            default:  mem_state_d = MEM_IDLE;
        endcase
    end

    assign fu_avail_d = {mem_state_d == MEM_IDLE, alu_free_d};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_state_q <= MEM_IDLE;
            mem_tag_q   <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_data_q  <= '0;
            mem_we_q    <= 1'b0;
            fu_avail_q  <= '1;
        end else begin
            mem_state_q <= mem_state_d;
            mem_tag_q   <= mem_tag_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_data_q  <= mem_data_d;
            mem_we_q    <= mem_we_d;
            fu_avail_q  <= fu_avail_d;
        end
    end

    assign fu_avail_o      = fu_avail_q;
    assign mem_req_valid_o = (mem_state_q == MEM_REQ);
    assign mem_we_o        = mem_we_q;
    assign mem_addr_o      = mem_addr_q;
    assign mem_wdata_o     = mem_wdata_q;

    always_comb begin
        wb_valid_o = '0;
        wb_tag_o   = '0;
        wb_data_o  = '0;
        if (mem_full) begin
            wb_valid_o[0]           = 1'b1;
            wb_tag_o[0 +: TAG_W]    = mem_tag_q;
            wb_data_o[0 +: XLEN]    = mem_data_q;
        end else if (alu_full[0]) begin
            wb_valid_o[0]           = 1'b1;
            wb_tag_o[0 +: TAG_W]    = alu_tag[0];
            wb_data_o[0 +: XLEN]    = alu_data[0];
        end else if (alu_full[1]) begin
            wb_valid_o[0]           = 1'b1;
            wb_tag_o[0 +: TAG_W]    = alu_tag[1];
            wb_data_o[0 +: XLEN]    = alu_data[1];
        end
        if (mem_full && alu_full[0]) begin
            wb_valid_o[1]           = 1'b1;
            wb_tag_o[TAG_W +: TAG_W] = alu_tag[0];
            wb_data_o[XLEN +: XLEN]  = alu_data[0];
        end else if ((mem_full || alu_full[0]) && alu_full[1]) begin
            wb_valid_o[1]           = 1'b1;
            wb_tag_o[TAG_W +: TAG_W] = alu_tag[1];
            wb_data_o[XLEN +: XLEN]  = alu_data[1];
        end
    end

endmodule

// File: tb/tb_fu_writeback_unit.sv
// Directed bench for fu_writeback_unit: ALU ops, port arbitration, LW/SW handshake
// and asynchronous reset in the middle of a load.
module tb_fu_writeback_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  iss_valid;
    logic [20:0] iss_opcode;
    logic [8:0]  iss_alu_op;
    logic [17:0] iss_rd;
    logic [95:0] iss_src1, iss_src2, iss_imm;
    logic [2:0]  fu_avail;
    logic        mem_req_valid, mem_req_ready, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_resp_valid;
    logic [1:0]  wb_valid;
    logic [11:0] wb_tag;
    logic [63:0] wb_data;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    fu_writeback_unit dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .iss_valid_i      (iss_valid),
        .iss_opcode_i     (iss_opcode),
        .iss_alu_op_i     (iss_alu_op),
        .iss_rd_i         (iss_rd),
        .iss_src1_i       (iss_src1),
        .iss_src2_i       (iss_src2),
        .iss_imm_i        (iss_imm),
        .fu_avail_o       (fu_avail),
        .mem_req_valid_o  (mem_req_valid),
        .mem_req_ready_i  (mem_req_ready),
        .mem_we_o         (mem_we),
        .mem_addr_o       (mem_addr),
        .mem_wdata_o      (mem_wdata),
        .mem_resp_valid_i (mem_resp_valid),
        .mem_rdata_i      (mem_rdata),
        .wb_valid_o       (wb_valid),
        .wb_tag_o         (wb_tag),
        .wb_data_o        (wb_data)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
        $display("check %-12s observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input int fu, input logic [6:0] op, input logic [2:0] aop,
                         input logic [5:0] rd, input logic [31:0] s1,
                         input logic [31:0] s2, input logic [31:0] imm);
        iss_valid[fu]          = 1'b1;
        iss_opcode[fu*7 +: 7]  = op;
        iss_alu_op[fu*3 +: 3]  = aop;
        iss_rd[fu*6 +: 6]      = rd;
        iss_src1[fu*32 +: 32]  = s1;
        iss_src2[fu*32 +: 32]  = s2;
        iss_imm[fu*32 +: 32]   = imm;
    endtask

    initial begin
        rst_n = 1'b0; iss_valid = '0; iss_opcode = '0; iss_alu_op = '0; iss_rd = '0;
        iss_src1 = '0; iss_src2 = '0; iss_imm = '0;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_rdata = '0;
        tick(); tick();
        chk("rst_avail", fu_avail, 3'b111);
        chk("rst_wbv", wb_valid, 2'b00);
        chk("rst_req", mem_req_valid, 1'b0);
        chk("rst_we", mem_we, 1'b0);
        chk("rst_addr", mem_addr, 32'h0);
        chk("rst_wdata", mem_wdata, 32'h0);
        chk("rst_wbdata", {wb_tag, wb_data}, 76'h0);
        rst_n = 1'b1;
        tick();

        // 1: ADD on ALU0
        issue(0, 7'b0110011, 3'd0, 6'd12, 32'd5, 32'd7, 32'd0);
        tick(); iss_valid = '0;
        chk("t1_wbv", wb_valid, 2'b01);
        chk("t1_tag", wb_tag[5:0], 6'd12);
        chk("t1_data", wb_data[31:0], 32'd12);
        chk("t1_busy", fu_avail, 3'b110);
        tick();
        chk("t1_avail", fu_avail, 3'b111);
        chk("t1_wbv_off", wb_valid, 2'b00);

        // 2: SRA on ALU1 and ANDI on ALU0 together
        issue(1, 7'b0110011, 3'd3, 6'd9, 32'h80000000, 32'd4, 32'd0);
        issue(0, 7'b0010011, 3'd4, 6'd3, 32'hFF, 32'h123, 32'h0F);
        tick(); iss_valid = '0;
        chk("t2_wbv", wb_valid, 2'b11);
        chk("t2_tag0", wb_tag[5:0], 6'd3);
        chk("t2_data0", wb_data[31:0], 32'h0F);
        chk("t2_tag1", wb_tag[11:6], 6'd9);
        chk("t2_data1", wb_data[63:32], 32'hF8000000);
        tick();
        chk("t2_avail", fu_avail, 3'b111);

        // 3: LW with ready low for three cycles
        issue(2, 7'b0000011, 3'd0, 6'd20, 32'h100, 32'd0, 32'hFFFFFFFC);
        tick(); iss_valid = '0;
        chk("t3_req", mem_req_valid, 1'b1);
        chk("t3_we", mem_we, 1'b0);
        chk("t3_addr_a", mem_addr, 32'h0FC);
        chk("t3_busy", fu_avail[2], 1'b0);
        mem_resp_valid = 1'b1; mem_rdata = 32'hBAD;
        tick();
        mem_resp_valid = 1'b0;
        chk("t3_addr_b", mem_addr, 32'h0FC);
        chk("t3_req_b", mem_req_valid, 1'b1);
        tick();
        chk("t3_addr_c", mem_addr, 32'h0FC);
        mem_req_ready = 1'b1;
        tick(); mem_req_ready = 1'b0;
        chk("t3_req_off", mem_req_valid, 1'b0);
        tick();
        chk("t3_wait_wbv", wb_valid, 2'b00);
        chk("t3_wait_av", fu_avail[2], 1'b0);
        mem_resp_valid = 1'b1; mem_rdata = 32'hDEAD;
        tick(); mem_resp_valid = 1'b0;
        chk("t3_wbv", wb_valid, 2'b01);
        chk("t3_tag", wb_tag[5:0], 6'd20);
        chk("t3_data", wb_data[31:0], 32'hDEAD);
        chk("t3_done_av", fu_avail[2], 1'b0);
        tick();
        chk("t3_avail", fu_avail, 3'b111);
        chk("t3_wbv_off", wb_valid, 2'b00);

        // 4: MEM DONE, ALU0 and ALU1 all complete in the same cycle
        issue(2, 7'b0000011, 3'd0, 6'd30, 32'h40, 32'd0, 32'd4);
        mem_req_ready = 1'b1;
        tick(); iss_valid = '0;
        tick(); mem_req_ready = 1'b0;
        mem_resp_valid = 1'b1; mem_rdata = 32'h1234;
        issue(0, 7'b0110011, 3'd0, 6'd31, 32'd1, 32'd2, 32'd0);
        issue(1, 7'b0110011, 3'd1, 6'd32, 32'd10, 32'd3, 32'd0);
        tick(); iss_valid = '0; mem_resp_valid = 1'b0;
        chk("t4_wbv", wb_valid, 2'b11);
        chk("t4_tag0", wb_tag[5:0], 6'd30);
        chk("t4_data0", wb_data[31:0], 32'h1234);
        chk("t4_tag1", wb_tag[11:6], 6'd31);
        chk("t4_data1", wb_data[63:32], 32'd3);
        chk("t4_busy", fu_avail, 3'b000);
        tick();
        chk("t4_wbv_b", wb_valid, 2'b01);
        chk("t4_tag_b", wb_tag[5:0], 6'd32);
        chk("t4_data_b", wb_data[31:0], 32'd7);
        chk("t4_avail_b", fu_avail, 3'b101);
        tick();
        chk("t4_avail_c", fu_avail, 3'b111);

        // 5: SW, then reset during LW WAIT
        issue(2, 7'b0100011, 3'd0, 6'd0, 32'h20, 32'h55, 32'd8);
        mem_req_ready = 1'b1;
        tick(); iss_valid = '0;
        chk("t5_req", mem_req_valid, 1'b1);
        chk("t5_we", mem_we, 1'b1);
        chk("t5_addr", mem_addr, 32'h28);
        chk("t5_wdata", mem_wdata, 32'h55);
        chk("t5_wbv", wb_valid, 2'b00);
        tick();
        chk("t5_req_off", mem_req_valid, 1'b0);
        chk("t5_wbv_b", wb_valid, 2'b00);
        chk("t5_avail", fu_avail, 3'b111);
        issue(2, 7'b0000011, 3'd0, 6'd5, 32'h300, 32'd0, 32'd0);
        tick(); iss_valid = '0;
        tick(); mem_req_ready = 1'b0;
        chk("t5_wait_av", fu_avail[2], 1'b0);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_avail", fu_avail, 3'b111);
        chk("t5_rst_req", mem_req_valid, 1'b0);
        chk("t5_rst_addr", mem_addr, 32'h0);
        chk("t5_rst_wbv", wb_valid, 2'b00);
        tick();
        rst_n = 1'b1;
        mem_resp_valid = 1'b1; mem_rdata = 32'hBEEF;
        tick(); mem_resp_valid = 1'b0;
        chk("t5_ign_wbv", wb_valid, 2'b00);
        chk("t5_ign_av", fu_avail, 3'b111);
        tick();
        chk("t5_ign_wbv2", wb_valid, 2'b00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
